// File: rtl/riscv_cpu_pkg.sv
// Shared types for the 5-stage core pipeline control.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package riscv_cpu_pkg;

    // Register-file address width used by the scoreboard entries.
    localparam int unsigned REG_ADDR_W = 5;

    // Operand forwarding source, youngest producer first after REG.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // One in-flight destination record held per pipeline stage.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

    // A stage produces rs only if it really writes it; x0 is hardwired zero.
    function automatic logic sb_match(input sb_entry_t e,
                                      input logic [REG_ADDR_W-1:0] rs,
                                      input logic rs_used);
        return e.valid & e.we & (e.rd == rs) & (rs != '0) & rs_used;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward select and load-use detect against the EX/MEM/WB scoreboard.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides stalls from load_use.
module hazard_fwd_sel
    import riscv_cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rs_used,
    input  sb_entry_t             ex_entry,
    input  sb_entry_t             mem_entry,
    input  sb_entry_t             wb_entry,
    output fwd_sel_e              fwd_sel,
    output logic                  load_use
);

    logic match_ex;
    logic match_mem;
    logic match_wb;

    assign match_ex  = sb_match(ex_entry,  rs, rs_used);
    assign match_mem = sb_match(mem_entry, rs, rs_used);
    assign match_wb  = sb_match(wb_entry,  rs, rs_used);

    // Youngest producer wins; a load in EX has no data yet, so it never forwards
    // and older stages must not be picked either (their value is stale).
    always_comb begin
        fwd_sel  = FWD_REG;
        load_use = match_ex & ex_entry.is_load;
        if (match_ex) begin
            fwd_sel = ex_entry.is_load ? FWD_REG : FWD_EX;
        end else if (match_mem) begin
            fwd_sel = FWD_MEM;
        end else if (match_wb) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: scoreboard of EX/MEM/WB writers, stall/flush/bubble and forward selects.
// Latency: controls are combinational from scoreboard + ID/EX inputs; scoreboard/counters update each edge.
// Backpressure: mem_stall_i freezes the whole pipe (scoreboard and counters hold).
module hazard_controller
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  id_valid_i,
    input  logic [ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [ADDR_WIDTH-1:0] id_rd_i,
    input  logic                  id_we_i,
    input  logic                  id_is_load_i,
    input  logic                  id_jal_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_stall_i,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  flush_if_o,
    output logic                  bubble_ex_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    // ADDR_WIDTH is expected to equal REG_ADDR_W; the scoreboard stores rd at that width.
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    sb_entry_t ex_q;
    sb_entry_t mem_q;
    sb_entry_t wb_q;

    fwd_sel_e  fwd_a;
    fwd_sel_e  fwd_b;
    logic      lu_a;
    logic      lu_b;
    logic      lu;
    logic      stall_inc;

    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    hazard_fwd_sel u_fwd_a (
        .rs        (id_rs1_i),
        .rs_used   (id_rs1_used_i),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .fwd_sel   (fwd_a),
        .load_use  (lu_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs        (id_rs2_i),
        .rs_used   (id_rs2_used_i),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .fwd_sel   (fwd_b),
        .load_use  (lu_b)
    );

    assign lu        = id_valid_i & (lu_a | lu_b);
    assign stall_inc = lu & ~mem_stall_i & ~ex_redirect_i;
    assign fwd_a_o   = fwd_a;
    assign fwd_b_o   = fwd_b;

    // Control priority: memory freeze > EX redirect > load-use > jump in ID.
    // A jal blocked by load-use does not flush; it is re-presented and flushes next cycle.
    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        flush_if_o  = 1'b0;
        bubble_ex_o = 1'b0;
        if (mem_stall_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
        end else if (ex_redirect_i) begin
            flush_if_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end else if (lu) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end else if (id_valid_i & id_jal_i) begin
            flush_if_o = 1'b1;
        end
    end

    // Scoreboard shifts one stage per unfrozen cycle; a bubble enters EX as invalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_stall_i) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble_ex_o) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid: id_valid_i, we: id_we_i, rd: id_rd_i, is_load: id_is_load_i};
            end
        end
    end

    // Saturating performance counters; flush_if_o is already low during a freeze.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_if_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, redirect, jal, freeze, reset.
// Latency: inputs driven at negedge, combinational outputs sampled 1ns later.
// Backpressure: mem_stall_i exercised as a 3-cycle freeze.
module tb_hazard_controller;

    logic        clk_i;
    logic        rst_ni;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic [4:0]  id_rd_i;
    logic        id_we_i;
    logic        id_is_load_i;
    logic        id_jal_i;
    logic        ex_redirect_i;
    logic        mem_stall_i;
    logic        stall_if_o;
    logic        stall_id_o;
    logic        flush_if_o;
    logic        bubble_ex_o;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    logic [3:0]  ctl;
    logic [3:0]  fwd;
    int          errors;
    int          checks;

    assign ctl = {stall_if_o, stall_id_o, flush_if_o, bubble_ex_o};
    assign fwd = {fwd_a_o, fwd_b_o};

    hazard_controller #(.ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_i       (id_rd_i),
        .id_we_i       (id_we_i),
        .id_is_load_i  (id_is_load_i),
        .id_jal_i      (id_jal_i),
        .ex_redirect_i (ex_redirect_i),
        .mem_stall_i   (mem_stall_i),
        .stall_if_o    (stall_if_o),
        .stall_id_o    (stall_id_o),
        .flush_if_o    (flush_if_o),
        .bubble_ex_o   (bubble_ex_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ctl = {stall_if, stall_id, flush_if, bubble_ex}; fwd = {fwd_a, fwd_b}

    task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        id_valid_i = 1'b1; id_rs1_i = r1; id_rs1_used_i = u1; id_rs2_i = r2;
        id_rs2_used_i = u2; id_rd_i = rd; id_we_i = we; id_is_load_i = ld;
        id_jal_i = 1'b0; ex_redirect_i = 1'b0; mem_stall_i = 1'b0;
    endtask

    task automatic idle();
        id_valid_i = 1'b0; id_rs1_i = '0; id_rs1_used_i = 1'b0; id_rs2_i = '0;
        id_rs2_used_i = 1'b0; id_rd_i = '0; id_we_i = 1'b0; id_is_load_i = 1'b0;
        id_jal_i = 1'b0; ex_redirect_i = 1'b0; mem_stall_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i); idle();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; idle();
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
        checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b want 0000", fwd); end
        checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt_o); end
        checks++; if (flush_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        checks++; if ({ctl, fwd} !== 8'h00) begin errors++; $display("FAIL reset_idle: got %h want 00", {ctl, fwd}); end
    endtask

    task automatic test_back_to_back();
        idle_cycles(3);
        @(negedge clk_i); drive(5'd1, 1, 5'd2, 1, 5'd5, 1, 0); #1;       // add x5,x1,x2
        checks++; if ({ctl, fwd} !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", {ctl, fwd}); end
        @(negedge clk_i); drive(5'd5, 1, 5'd5, 1, 5'd6, 1, 0); #1;       // add x6,x5,x5
        checks++; if (fwd !== 4'b0101) begin errors++; $display("FAIL b2b_fwd_ex: got %b want 0101", fwd); end
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL b2b_no_stall: got %b want 0000", ctl); end
        @(negedge clk_i); drive(5'd5, 1, 5'd0, 1, 5'd9, 1, 0); #1;       // x5 now in MEM
        checks++; if (fwd !== 4'b1000) begin errors++; $display("FAIL b2b_fwd_mem: got %b want 1000", fwd); end
        @(negedge clk_i); drive(5'd5, 1, 5'd6, 1, 5'd12, 0, 0); #1;      // x5 in WB, x6 in MEM
        checks++; if (fwd !== 4'b1110) begin errors++; $display("FAIL b2b_fwd_wb: got %b want 1110", fwd); end
        @(negedge clk_i); drive(5'd9, 0, 5'd6, 1, 5'd0, 0, 0); #1;       // x9 in MEM but rs1 unused
        checks++; if (fwd !== 4'b0011) begin errors++; $display("FAIL b2b_unused: got %b want 0011", fwd); end
        // Two writers of x10 back to back: EX must win over MEM.
        idle_cycles(3);
        @(negedge clk_i); drive(5'd0, 0, 5'd0, 0, 5'd10, 1, 0);
        @(negedge clk_i); drive(5'd0, 0, 5'd0, 0, 5'd10, 1, 0);
        @(negedge clk_i); drive(5'd10, 1, 5'd10, 1, 5'd0, 0, 0); #1;
        checks++; if (fwd !== 4'b0101) begin errors++; $display("FAIL b2b_youngest: got %b want 0101", fwd); end
    endtask

    task automatic test_load_use();
        idle_cycles(3);
        @(negedge clk_i); drive(5'd1, 1, 5'd0, 0, 5'd7, 1, 1); #1;       // lw x7
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL lu_load: got %b want 0000", ctl); end
        @(negedge clk_i); drive(5'd7, 1, 5'd0, 1, 5'd8, 1, 0); #1;       // add x8,x7,x0
        checks++; if (ctl !== 4'b1101) begin errors++; $display("FAIL lu_stall: got %b want 1101", ctl); end
        @(negedge clk_i); drive(5'd7, 1, 5'd0, 1, 5'd8, 1, 0); #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL lu_one_cycle: got %b want 0000", ctl); end
        checks++; if (fwd !== 4'b1000) begin errors++; $display("FAIL lu_fwd_mem: got %b want 1000", fwd); end
        checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_o); end
        @(negedge clk_i); idle(); #1;
        checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt_hold: got %0d want 1", stall_cnt_o); end
    endtask

    task automatic test_x0();
        idle_cycles(3);
        @(negedge clk_i); drive(5'd0, 1, 5'd0, 0, 5'd0, 1, 0);           // addi x0,x0,1
        @(negedge clk_i); drive(5'd0, 1, 5'd0, 0, 5'd0, 1, 1); #1;       // lw x0,0(x0)
        checks++; if ({ctl, fwd} !== 8'h00) begin errors++; $display("FAIL x0_after_addi: got %h want 00", {ctl, fwd}); end
        @(negedge clk_i); drive(5'd0, 1, 5'd0, 1, 5'd13, 1, 0); #1;      // reader of x0 behind lw x0
        checks++; if ({ctl, fwd} !== 8'h00) begin errors++; $display("FAIL x0_after_load: got %h want 00", {ctl, fwd}); end
        checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL x0_stall_cnt: got %0d want 1", stall_cnt_o); end
    endtask

    task automatic test_redirect();
        idle_cycles(3);
        @(negedge clk_i); drive(5'd1, 1, 5'd0, 0, 5'd3, 1, 1);           // lw x3
        @(negedge clk_i); drive(5'd3, 1, 5'd0, 0, 5'd3, 1, 1);           // lw x3,0(x3): lu candidate
        ex_redirect_i = 1'b1; id_jal_i = 1'b1; #1;
        checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL redir_ctl: got %b want 0011", ctl); end
        @(negedge clk_i); drive(5'd3, 1, 5'd0, 0, 5'd14, 1, 0); #1;      // killed load must not be in EX
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL redir_ex_invalid: got %b want 0000", ctl); end
        checks++; if (fwd !== 4'b1000) begin errors++; $display("FAIL redir_fwd: got %b want 1000", fwd); end
        checks++; if (flush_cnt_o !== 32'd1) begin errors++; $display("FAIL redir_flush_cnt: got %0d want 1", flush_cnt_o); end
        checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL redir_stall_cnt: got %0d want 1", stall_cnt_o); end
    endtask

    task automatic test_jal();
        idle_cycles(3);
        @(negedge clk_i); drive(5'd0, 0, 5'd0, 0, 5'd1, 1, 0); id_jal_i = 1'b1; #1;
        checks++; if (ctl !== 4'b0010) begin errors++; $display("FAIL jal_flush: got %b want 0010", ctl); end
        @(negedge clk_i); drive(5'd0, 0, 5'd0, 0, 5'd4, 1, 1); #1;       // lw x4
        checks++; if (flush_cnt_o !== 32'd2) begin errors++; $display("FAIL jal_flush_cnt: got %0d want 2", flush_cnt_o); end
        @(negedge clk_i); drive(5'd4, 1, 5'd0, 0, 5'd1, 1, 0); id_jal_i = 1'b1; #1;   // jalr x1,x4
        checks++; if (ctl !== 4'b1101) begin errors++; $display("FAIL jal_lu_stall: got %b want 1101", ctl); end
        @(negedge clk_i); drive(5'd4, 1, 5'd0, 0, 5'd1, 1, 0); id_jal_i = 1'b1; #1;
        checks++; if ({ctl, fwd} !== 8'h28) begin errors++; $display("FAIL jal_replay: got %h want 28", {ctl, fwd}); end
        checks++; if (stall_cnt_o !== 32'd2) begin errors++; $display("FAIL jal_stall_cnt: got %0d want 2", stall_cnt_o); end
        @(negedge clk_i); idle(); #1;
        checks++; if (flush_cnt_o !== 32'd3) begin errors++; $display("FAIL jal_flush_cnt2: got %0d want 3", flush_cnt_o); end
    endtask

    task automatic test_mem_stall();
        idle_cycles(3);
        @(negedge clk_i); drive(5'd0, 0, 5'd0, 0, 5'd11, 1, 0);          // add x11
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i); drive(5'd11, 1, 5'd0, 0, 5'd15, 1, 0);     // add x15,x11
            mem_stall_i = 1'b1; ex_redirect_i = (c == 1); #1;
            checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL mstall_ctl%0d: got %b want 1100", c, ctl); end
            checks++; if (fwd !== 4'b0100) begin errors++; $display("FAIL mstall_fwd%0d: got %b want 0100", c, fwd); end
        end
        @(negedge clk_i); drive(5'd11, 1, 5'd0, 0, 5'd15, 1, 0); #1;
        checks++; if ({ctl, fwd} !== 8'h04) begin errors++; $display("FAIL mstall_release: got %h want 04", {ctl, fwd}); end
        checks++; if (flush_cnt_o !== 32'd3) begin errors++; $display("FAIL mstall_flush_cnt: got %0d want 3", flush_cnt_o); end
        @(negedge clk_i); drive(5'd11, 1, 5'd15, 1, 5'd16, 1, 0); #1;
        checks++; if (fwd !== 4'b1001) begin errors++; $display("FAIL mstall_resume: got %b want 1001", fwd); end
    endtask

    task automatic test_reset_mid();
        idle_cycles(3);
        @(negedge clk_i); drive(5'd1, 1, 5'd0, 0, 5'd7, 1, 1);           // lw x7
        @(negedge clk_i); drive(5'd7, 1, 5'd0, 1, 5'd8, 1, 0); #1;
        checks++; if (ctl !== 4'b1101) begin errors++; $display("FAIL rmid_stall: got %b want 1101", ctl); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if ({ctl, fwd} !== 8'h00) begin errors++; $display("FAIL rmid_outputs: got %h want 00", {ctl, fwd}); end
        checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rmid_stall_cnt: got %0d want 0", stall_cnt_o); end
        checks++; if (flush_cnt_o !== 32'd0) begin errors++; $display("FAIL rmid_flush_cnt: got %0d want 0", flush_cnt_o); end
        @(negedge clk_i); rst_ni = 1'b1; #1;
        checks++; if ({ctl, fwd} !== 8'h00) begin errors++; $display("FAIL rmid_after: got %h want 00", {ctl, fwd}); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0();
        test_redirect();
        test_jal();
        test_mem_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
